chip_echo_shell: RTL and testbench

Chip-level I/O shell for the manycore test chip, clocked by `io_clk`. It receives 32-bit flits on three credit-flow-controlled virtual channels and buffers each channel separately. Each flit is echoed back out on the same channel, with round-robin arbitration and per-channel output credits. It also produces a PLL-lock indication. Analog, PLL, ORAM and JTAG pins are terminated here, so a playback bench can exercise the full chip pin list.

---
 rtl/chip_echo_pkg.sv | 11 +
 rtl/chip_echo_fifo.sv | 54 +++++
 rtl/chip_echo_shell.sv | 144 ++++++++++++++
 tb/tb_chip_echo_shell.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/chip_echo_pkg.sv
// rtl/chip_echo_pkg.sv - shared sizes, channel codes and flit type for the echo shell
package chip_echo_pkg;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 4;

  localparam logic [1:0] CH_IDLE = 2'b00;
  localparam int         CH_BASE = 1;

  typedef logic [DATA_W-1:0] flit_t;
endpackage

// File: rtl/chip_echo_fifo.sv
// rtl/chip_echo_fifo.sv - per-channel input FIFO; a push into a full FIFO is kept only when popped that cycle
module chip_echo_fifo
  import chip_echo_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int D = DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(D));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/chip_echo_shell.sv
// rtl/chip_echo_shell.sv - chip I/O shell: per-channel buffering, round-robin credited echo, PLL lock model
module chip_echo_shell #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 3,
  parameter int DEPTH       = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              io_clk,
  input  logic              rst_n,
  input  logic              pll_rst_n,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] intf_chip_data,
  input  logic [1:0]        intf_chip_channel,
  output logic [NUM_CH-1:0] intf_chip_credit_back,
  output logic [DATA_W-1:0] chip_intf_data,
  output logic [1:0]        chip_intf_channel,
  input  logic [NUM_CH-1:0] chip_intf_credit_back,
  output logic              pll_lock,
  output logic              jtag_dataout,
  input  logic              core_ref_clk,
  input  logic              jtag_clk,
  input  logic              jtag_rst_l,
  input  logic              jtag_modesel,
  input  logic              jtag_datain,
  input  logic              slew,
  input  logic              impsel1,
  input  logic              impsel2,
  input  logic              async_mux,
  input  logic              pll_bypass,
  input  logic [4:0]        pll_rangea,
  input  logic [1:0]        clk_mux_sel,
  input  logic              oram_on,
  input  logic              oram_traffic_gen,
  input  logic              oram_dummy_gen
);
  import chip_echo_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] eligible;
  logic [DATA_W-1:0] head [NUM_CH];
  logic [CW-1:0]     ocred [NUM_CH];
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_valid;
  logic [LW-1:0]     lock_cnt;
  logic              unused_ok;

  assign jtag_dataout = 1'b0;
  assign unused_ok = &{1'b0, core_ref_clk, jtag_clk, jtag_rst_l, jtag_modesel, jtag_datain,
                       slew, impsel1, impsel2, async_mux, pll_bypass, pll_rangea,
                       clk_mux_sel, oram_on, oram_traffic_gen, oram_dummy_gen, full};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    chip_echo_fifo #(.W(DATA_W), .D(DEPTH)) u_fifo (
      .clk       (io_clk),
      .rst_n     (rst_n),
      .push      (push[c]),
      .push_data (intf_chip_data),
      .pop       (pop[c]),
      .full      (full[c]),
      .empty     (empty[c]),
      .head      (head[c])
    );
  end

  always_comb begin
    push     = '0;
    eligible = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push[c]     = (intf_chip_channel != CH_IDLE) && (intf_chip_channel == 2'(c + CH_BASE));
      eligible[c] = clk_en && !empty[c] && (ocred[c] != '0);
    end
  end

  // Scan channels starting at the round-robin pointer; first eligible wins.
  always_comb begin
    int idx;
    idx       = 0;
    pop       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
    if (gnt_valid) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_intf_data        <= '0;
      chip_intf_channel     <= CH_IDLE;
      intf_chip_credit_back <= '0;
      rr_ptr                <= '0;
    end else if (gnt_valid) begin
      chip_intf_data        <= head[gnt_idx];
      chip_intf_channel     <= 2'(int'(gnt_idx) + CH_BASE);
      intf_chip_credit_back <= pop;
      rr_ptr                <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end else begin
      chip_intf_data        <= '0;
      chip_intf_channel     <= CH_IDLE;
      intf_chip_credit_back <= '0;
    end
  end

  // A send and a return together cancel; returns beyond DEPTH are dropped.
  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) ocred[c] <= CW'(DEPTH);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pop[c] && !chip_intf_credit_back[c])
          ocred[c] <= ocred[c] - 1'b1;
        else if (!pop[c] && chip_intf_credit_back[c] && (ocred[c] < CW'(DEPTH)))
          ocred[c] <= ocred[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge io_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      pll_lock <= 1'b0;
    end else if (!pll_rst_n) begin
      lock_cnt <= '0;
      pll_lock <= 1'b0;
    end else begin
      if (lock_cnt != LW'(LOCK_CYCLES - 1)) lock_cnt <= lock_cnt + 1'b1;
      pll_lock <= (lock_cnt == LW'(LOCK_CYCLES - 1));
    end
  end
endmodule

// File: tb/tb_chip_echo_shell.sv
// tb/tb_chip_echo_shell.sv - directed self-checking bench for chip_echo_shell
module tb_chip_echo_shell;
  logic        io_clk = 1'b0;
  logic        rst_n, pll_rst_n, clk_en;
  logic [31:0] intf_chip_data;
  logic [1:0]  intf_chip_channel;
  logic [2:0]  intf_chip_credit_back;
  logic [31:0] chip_intf_data;
  logic [1:0]  chip_intf_channel;
  logic [2:0]  chip_intf_credit_back;
  logic        pll_lock, jtag_dataout;
  logic        tie0 = 1'b0;
  logic [4:0]  tie5 = 5'd0;
  logic [1:0]  tie2 = 2'd0;

  int checks = 0;
  int errors = 0;

  always #5 io_clk = ~io_clk;

  chip_echo_shell dut (
    .io_clk                (io_clk),
    .rst_n                 (rst_n),
    .pll_rst_n             (pll_rst_n),
    .clk_en                (clk_en),
    .intf_chip_data        (intf_chip_data),
    .intf_chip_channel     (intf_chip_channel),
    .intf_chip_credit_back (intf_chip_credit_back),
    .chip_intf_data        (chip_intf_data),
    .chip_intf_channel     (chip_intf_channel),
    .chip_intf_credit_back (chip_intf_credit_back),
    .pll_lock              (pll_lock),
    .jtag_dataout          (jtag_dataout),
    .core_ref_clk          (tie0),
    .jtag_clk              (tie0),
    .jtag_rst_l            (tie0),
    .jtag_modesel          (tie0),
    .jtag_datain           (tie0),
    .slew                  (tie0),
    .impsel1               (tie0),
    .impsel2               (tie0),
    .async_mux             (tie0),
    .pll_bypass            (tie0),
    .pll_rangea            (tie5),
    .clk_mux_sel           (tie2),
    .oram_on               (tie0),
    .oram_traffic_gen      (tie0),
    .oram_dummy_gen        (tie0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ch, input logic [31:0] data,
                         input logic [2:0] cred);
    chk({tag, ".channel"}, 64'(chip_intf_channel), 64'(ch));
    chk({tag, ".data"}, 64'(chip_intf_data), 64'(data));
    chk({tag, ".credit"}, 64'(intf_chip_credit_back), 64'(cred));
  endtask

  task automatic step();
    @(posedge io_clk);
    @(negedge io_clk);
  endtask

  task automatic send(input logic [1:0] ch, input logic [31:0] data);
    intf_chip_channel = ch;
    intf_chip_data    = data;
    step();
    intf_chip_channel = 2'b00;
    intf_chip_data    = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge io_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pll_rst_n = 1'b1; clk_en = 1'b1;
    intf_chip_data = 32'd0; intf_chip_channel = 2'b00; chip_intf_credit_back = 3'b000;
    repeat (3) @(negedge io_clk);
    chk_out("reset", 2'b00, 32'd0, 3'b000);
    chk("reset.pll_lock", 64'(pll_lock), 64'd0);
    chk("reset.jtag_dataout", 64'(jtag_dataout), 64'd0);

    rst_n = 1'b1;
    repeat (15) step();
    chk("lock.edge15", 64'(pll_lock), 64'd0);
    step();
    chk("lock.edge16", 64'(pll_lock), 64'd1);

    pll_rst_n = 1'b0;
    step();
    chk("lockrst.cleared", 64'(pll_lock), 64'd0);
    pll_rst_n = 1'b1;
    repeat (15) step();
    chk("lockrst.edge15", 64'(pll_lock), 64'd0);
    step();
    chk("lockrst.edge16", 64'(pll_lock), 64'd1);

    // Single echo: idle after sampling edge, visible after the next one.
    send(2'b01, 32'hDEADBEEF);
    chk_out("echo.lat0", 2'b00, 32'd0, 3'b000);
    step();
    chk_out("echo", 2'b01, 32'hDEADBEEF, 3'b001);
    step();
    chk_out("echo.after", 2'b00, 32'd0, 3'b000);

    // Credit exhaustion on channel 10.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      send(2'b10, 32'hA000_0000 + 32'(i - 1));
      if (i == 1 || i == 6) chk_out($sformatf("cred.%0d", i), 2'b00, 32'd0, 3'b000);
      else chk_out($sformatf("cred.%0d", i), 2'b10, 32'hA000_0000 + 32'(i - 2), 3'b010);
    end
    step();
    chk_out("cred.starved", 2'b00, 32'd0, 3'b000);
    chip_intf_credit_back = 3'b010;
    step();
    chip_intf_credit_back = 3'b000;
    chk_out("cred.return", 2'b00, 32'd0, 3'b000);
    step();
    chk_out("cred.fifth", 2'b10, 32'hA000_0004, 3'b010);
    step();
    chk_out("cred.sixth_held", 2'b00, 32'd0, 3'b000);

    // Round-robin.
    do_reset();
    clk_en = 1'b0;
    send(2'b01, 32'h1111_0001);
    send(2'b10, 32'h2222_0002);
    send(2'b11, 32'h3333_0003);
    chk_out("rr.stalled", 2'b00, 32'd0, 3'b000);
    clk_en = 1'b1;
    step();
    chk_out("rr.first", 2'b01, 32'h1111_0001, 3'b001);
    step();
    chk_out("rr.second", 2'b10, 32'h2222_0002, 3'b010);
    step();
    chk_out("rr.third", 2'b11, 32'h3333_0003, 3'b100);
    step();
    chk_out("rr.idle", 2'b00, 32'd0, 3'b000);

    // Overflow: fifth flit dropped.
    do_reset();
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) send(2'b11, 32'hC000_0000 + 32'(i));
    clk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("ovf.%0d", i), 2'b11, 32'hC000_0000 + 32'(i), 3'b100);
    end
    chip_intf_credit_back = 3'b100;
    step();
    chip_intf_credit_back = 3'b000;
    chk_out("ovf.none_a", 2'b00, 32'd0, 3'b000);
    step();
    chk_out("ovf.none_b", 2'b00, 32'd0, 3'b000);

    // Full FIFO with simultaneous pop accepts the push.
    do_reset();
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b01, 32'hD000_0000 + 32'(i));
    clk_en = 1'b1;
    send(2'b01, 32'hD000_0004);
    chk_out("fullpop.0", 2'b01, 32'hD000_0000, 3'b001);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_out($sformatf("fullpop.%0d", i), 2'b01, 32'hD000_0000 + 32'(i), 3'b001);
    end
    step();
    chk_out("fullpop.starved", 2'b00, 32'd0, 3'b000);
    chip_intf_credit_back = 3'b001;
    step();
    chip_intf_credit_back = 3'b000;
    step();
    chk_out("fullpop.kept", 2'b01, 32'hD000_0004, 3'b001);

    // Asynchronous reset mid-traffic discards queued flits.
    do_reset();
    clk_en = 1'b0;
    send(2'b10, 32'hE000_0000);
    send(2'b10, 32'hE000_0001);
    clk_en = 1'b1;
    step();
    chk_out("midrst.before", 2'b10, 32'hE000_0000, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk_out("midrst.async", 2'b00, 32'd0, 3'b000);
    @(negedge io_clk);
    rst_n = 1'b1;
    step();
    chk_out("midrst.discarded", 2'b00, 32'd0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
